// File: rtl/ram_writeback_controller.sv
// Latches a result vector/matrix at start and streams it into RAM one word per cycle.
// Optional macro WB_STALL_EN adds a ram_ready input that stalls the stream.
module ram_writeback_controller #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 20,
    parameter int MAX_DIM = 32,
    parameter int DIM_W   = 6
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              mode,
    input  logic [ADDR_W-1:0]                 base_address,
    input  logic [DIM_W-1:0]                  vector_L,
    input  logic [DIM_W-1:0]                  matrix_M,
    input  logic [DIM_W-1:0]                  matrix_N,
    input  logic [MAX_DIM*DATA_W-1:0]         vector_in,
    input  logic [MAX_DIM*MAX_DIM*DATA_W-1:0] matrix_in,
`ifdef WB_STALL_EN
    input  logic                              ram_ready,
`endif
    output logic                              write_block,
    output logic [ADDR_W-1:0]                 address_block,
    output logic [DATA_W-1:0]                 data_in,
    output logic                              busy,
    output logic                              done,
    output logic                              error
);

    localparam int IDX_W = $clog2(MAX_DIM*MAX_DIM);
    localparam logic [DIM_W-1:0] MAX_D = DIM_W'(MAX_DIM);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t                            state;
    logic [MAX_DIM*MAX_DIM*DATA_W-1:0] payload;
    logic [DIM_W-1:0]                  rows, cols, row, col, next_row, next_col;
    logic                              dims_ok, last_col, last_elem, accept, take;
    logic [IDX_W-1:0]                  next_idx;

    function automatic logic dim_ok(input logic [DIM_W-1:0] d);
        return (d != '0) && (d <= MAX_D);
    endfunction

    assign dims_ok = mode ? (dim_ok(matrix_M) && dim_ok(matrix_N)) : dim_ok(vector_L);
    assign take    = (state == IDLE) && start && dims_ok;

`ifdef WB_STALL_EN
    assign accept = ram_ready;
`else
    assign accept = 1'b1;
`endif

    // Vector mode is a 1 x L matrix, so one row/col walker serves both modes.
    assign last_col  = (col == cols - DIM_W'(1));
    assign last_elem = last_col && (row == rows - DIM_W'(1));
    assign next_row  = last_col ? row + DIM_W'(1) : row;
    assign next_col  = last_col ? '0 : col + DIM_W'(1);
    assign next_idx  = IDX_W'(next_row) * IDX_W'(MAX_DIM) + IDX_W'(next_col);

    // Payload buffer needs no reset: it is only read after a start has filled it.
    always_ff @(posedge clk) begin
        if (take) begin
            if (mode) payload <= matrix_in;
            else      payload[MAX_DIM*DATA_W-1:0] <= vector_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            write_block   <= 1'b0;
            address_block <= '0;
            data_in       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            rows          <= '0;
            cols          <= '0;
            row           <= '0;
            col           <= '0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (dims_ok) begin
                            state         <= WRITE;
                            busy          <= 1'b1;
                            write_block   <= 1'b1;
                            address_block <= base_address;
                            data_in       <= mode ? matrix_in[DATA_W-1:0] : vector_in[DATA_W-1:0];
                            rows          <= mode ? matrix_M : DIM_W'(1);
                            cols          <= mode ? matrix_N : vector_L;
                            row           <= '0;
                            col           <= '0;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (accept) begin
                        if (last_elem) begin
                            state         <= DONE;
                            write_block   <= 1'b0;
                            address_block <= '0;
                            data_in       <= '0;
                            done          <= 1'b1;
                        end else begin
                            address_block <= address_block + ADDR_W'(1);
                            data_in       <= payload[next_idx*DATA_W +: DATA_W];
                            row           <= next_row;
                            col           <= next_col;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/ram_writeback_controller.md
Name: ram_writeback_controller

Overview:
- Write-side counterpart of the random_access_memory read paths (read_vector / read_matrix).
- Takes a result vector or matrix from the compute array, latches it, and streams it into RAM one 16-bit word per cycle over the RAM single-word write port (write_block / address_block / data_in).
- Sits between the systolic array output and random_access_memory.
- Controlled by a start/busy/done handshake from the TTPU sequencer.

Parameters:
- DATA_W, 16, word width
- ADDR_W, 20, RAM address width
- MAX_DIM, 32, maximum vector length and matrix rows/columns
- DIM_W, 6, width of the dimension inputs (holds 0..63)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- mode  in  1  0 = vector, 1 = matrix
- base_address  in  ADDR_W  RAM address of element 0
- vector_L  in  DIM_W  vector length
- matrix_M  in  DIM_W  matrix rows
- matrix_N  in  DIM_W  matrix columns
- vector_in  in  MAX_DIM*DATA_W  element k at bits [k*DATA_W +: DATA_W]
- matrix_in  in  MAX_DIM*MAX_DIM*DATA_W  element (i,j) at index i*MAX_DIM+j
- write_block  out  1  RAM write strobe
- address_block  out  ADDR_W  RAM write address
- data_in  out  DATA_W  RAM write data
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- error  out  1  one-cycle pulse on an illegal dimension

Behaviour:
- Reset (asynchronous, rst_n low):
  - All outputs go to 0 immediately.
  - FSM goes to IDLE; counters clear.
  - Reset mid-transfer abandons the remaining writes. No partial pulse follows reset release.
- FSM states: IDLE, WRITE, DONE.
- IDLE:
  - start=1 with legal dimensions: latch mode, base_address, dimensions, and the selected payload into an internal buffer. Go to WRITE.
  - Illegal dimensions: vector_L, matrix_M or matrix_N is 0 or greater than MAX_DIM (only the dimensions used by the selected mode are checked). Pulse error for 1 cycle, stay in IDLE, issue no writes.
- WRITE:
  - One write per cycle: write_block=1, with address_block and data_in registered.
  - Vector mode: element k goes to base_address+k, for k = 0..L-1.
  - Matrix mode: row-major, (i,j) goes to base_address + i*N + j, with j fastest.
  - After the final element, go to DONE.
- DONE: done=1 for one cycle, write_block=0, then go to IDLE.
- Timing: start sampled at edge t0.
  - busy=1 from the cycle after t0 through the DONE cycle inclusive.
  - write_block=1 for exactly L (or M*N) consecutive cycles, beginning the cycle after t0.
  - done is high in the cycle after the last write.
  - Total latency is L+1 cycles from start to done.
- Address arithmetic: modulo 2^ADDR_W. Wrap-around past 0xFFFFF continues at 0x00000 without error.
- Input isolation: changes to payload or dimension inputs while busy have no effect, because all values are latched at start.
- start while busy (WRITE or DONE): ignored, not queued. The next start is accepted from the first IDLE cycle after done.
- Idle bus values: when write_block=0, address_block and data_in hold 0.

Optional Feature:
- Macro: WB_STALL_EN.
- Defined:
  - Adds input ram_ready (1 bit).
  - In WRITE, write_block stays asserted and address_block/data_in stay stable until ram_ready=1. The element advances only on a cycle where write_block and ram_ready are both 1.
  - done follows the cycle after the final accepted write.
  - Latency becomes (number of elements + stall cycles + 1).
- Undefined: no ram_ready port; every WRITE cycle is treated as accepted.

Test Plan:
1. Vector write:
   - Stimulus: mode=0, vector_L=4, base=0x00010, elements 0x1111, 0x2222, 0x3333, 0x4444.
   - Required: 4 consecutive writes to addresses 0x10..0x13 with those data; done in cycle 5 after start; busy spans cycles 1-5.
2. Matrix row-major write:
   - Stimulus: mode=1, M=2, N=3, base=0x00100, (i,j) value = 0x0ij.
   - Required: addresses 0x100..0x105 carry 0x000, 0x001, 0x002, 0x010, 0x011, 0x012.
3. Illegal dimensions:
   - Stimulus: vector_L=0, then matrix_N=33.
   - Required: a one-cycle error pulse each time; write_block never asserted; busy stays 0.
4. Wrap-around and start-while-busy:
   - Stimulus: base=0xFFFFE, L=4; pulse start again in write cycle 2.
   - Required: addresses 0xFFFFE, 0xFFFFF, 0x00000, 0x00001; the second start is ignored; exactly one done pulse.
5. Reset mid-transfer:
   - Stimulus: L=32; rst_n low after 10 writes.
   - Required: all outputs are 0 in the same cycle; after release, no writes and no done until a new start.
6. WB_STALL_EN:
   - Stimulus: L=3, ram_ready low for 2 cycles during element 1.
   - Required: element 1 address/data held for 3 cycles; 3 accepted writes total; done at cycle 6 after start.
